// File: rtl/video_fetch_if.sv
// Word-request bus between the video fetcher (master) and the DRAM video arbiter (slave).
// The arbiter grants with video_next and returns data with video_strobe.
interface video_fetch_if;
    logic        video_go;
    logic        video_next;
    logic        video_strobe;
    logic [15:0] video_data;

    modport master (
        output video_go,
        input  video_next,
        input  video_strobe,
        input  video_data
    );

    modport slave (
        input  video_go,
        output video_next,
        output video_strobe,
        output video_data
    );
endinterface

// File: rtl/video_fetch.sv
// Video data fetcher: assembles four 16-bit DRAM words into a 64-bit pixel group and
// hands it to the renderer on each cbeg-aligned fetch_sync, prefetching the next group.
module video_fetch #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_cbeg,
    input  logic                 i_fetch_start,
    input  logic                 i_pix_start,
    input  logic                 i_pix_stop,
    input  logic                 i_mode_16c,
    input  logic                 i_mode_pixf_14,
    input  logic                 i_int_start,
    video_fetch_if.master        vid,
    output logic [63:0]          o_pic_bits,
    output logic                 o_fetch_sync,
    output logic                 o_underrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_req_cnt;
    logic [2:0]  r_rcv_cnt;
    logic [63:0] r_fbuf;
    logic        r_line_act;
    logic [4:0]  r_sync_cnt;
    logic        r_video_go;
    logic [63:0] r_pic_bits;
    logic        r_underrun;

    logic [2:0]  w_req_nxt;
    logic [2:0]  w_rcv_nxt;
    logic [63:0] w_fbuf_nxt;
    logic [5:0]  w_period;
    logic        w_wrap;
    logic        w_sync;
    logic        w_full_now;

    // Next counter and buffer values after this clk's grant/strobe
    always_comb begin
        w_req_nxt  = r_req_cnt;
        w_rcv_nxt  = r_rcv_cnt;
        w_fbuf_nxt = r_fbuf;
        if (vid.video_next && (r_req_cnt < 3'(WORDS))) begin
            w_req_nxt = r_req_cnt + 3'd1;
        end else begin
            w_req_nxt = r_req_cnt;
        end
        if (vid.video_strobe && (r_rcv_cnt < 3'(WORDS))) begin
            w_rcv_nxt = r_rcv_cnt + 3'd1;
            w_fbuf_nxt[{r_rcv_cnt[1:0], 4'd0} +: 16] = vid.video_data;
        end else begin
            w_rcv_nxt = r_rcv_cnt;
        end
    end

    // Sync period and group-boundary detection; a 4th word landing this clk counts as full
    always_comb begin
        w_period   = (i_mode_16c ? 6'd16 : 6'd32) >> i_mode_pixf_14;
        w_wrap     = ({1'b0, r_sync_cnt} == (w_period - 6'd1));
        w_sync     = i_cbeg && (i_pix_start || (r_line_act && w_wrap));
        w_full_now = (r_state == ST_FULL) ||
                     ((r_state == ST_FETCH) && (w_rcv_nxt == 3'(WORDS)));
    end

    assign o_fetch_sync = w_sync;
    assign vid.video_go = r_video_go;
    assign o_pic_bits   = r_pic_bits;
    assign o_underrun   = r_underrun;

    // cbeg tick counter that paces fetch_sync within a line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_cnt <= 5'd0;
        end else if (i_cbeg && i_pix_start) begin
            r_sync_cnt <= 5'd0;
        end else if (i_cbeg && r_line_act) begin
            r_sync_cnt <= w_wrap ? 5'd0 : (r_sync_cnt + 5'd1);
        end
    end

    // Group hand-over to the renderer and sticky underrun flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pic_bits <= 64'd0;
            r_underrun <= 1'b0;
        end else begin
            if (w_sync && w_full_now) begin
                r_pic_bits <= w_fbuf_nxt;
            end
            if (w_sync && !w_full_now) begin
                r_underrun <= 1'b1;
            end else if (i_int_start) begin
                r_underrun <= 1'b0;
            end
        end
    end

    // Fetch state machine with registered word request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_req_cnt  <= 3'd0;
            r_rcv_cnt  <= 3'd0;
            r_fbuf     <= 64'd0;
            r_line_act <= 1'b0;
            r_video_go <= 1'b0;
        end else begin
            r_fbuf <= w_fbuf_nxt;
            if (i_pix_stop) begin
                // Granted words still in flight must be absorbed before going idle
                r_line_act <= 1'b0;
                r_video_go <= 1'b0;
                r_req_cnt  <= w_req_nxt;
                r_rcv_cnt  <= w_rcv_nxt;
                r_state    <= (w_req_nxt > w_rcv_nxt) ? ST_DRAIN : ST_IDLE;
            end else if (i_fetch_start) begin
                r_line_act <= 1'b1;
                r_video_go <= 1'b1;
                r_req_cnt  <= 3'd0;
                r_rcv_cnt  <= 3'd0;
                r_state    <= ST_FETCH;
            end else begin
                case (r_state)
                    ST_FETCH, ST_FULL: begin
                        if (w_sync && w_full_now) begin
                            r_req_cnt  <= 3'd0;
                            r_rcv_cnt  <= 3'd0;
                            r_video_go <= r_line_act;
                            r_state    <= r_line_act ? ST_FETCH : ST_IDLE;
                        end else if (w_rcv_nxt == 3'(WORDS)) begin
                            r_req_cnt  <= w_req_nxt;
                            r_rcv_cnt  <= w_rcv_nxt;
                            r_video_go <= 1'b0;
                            r_state    <= ST_FULL;
                        end else begin
                            r_req_cnt  <= w_req_nxt;
                            r_rcv_cnt  <= w_rcv_nxt;
                            r_video_go <= (w_req_nxt < 3'(WORDS));
                            r_state    <= ST_FETCH;
                        end
                    end
                    ST_DRAIN: begin
                        r_req_cnt  <= w_req_nxt;
                        r_rcv_cnt  <= w_rcv_nxt;
                        r_video_go <= 1'b0;
                        r_state    <= (w_rcv_nxt >= w_req_nxt) ? ST_IDLE : ST_DRAIN;
                    end
                    ST_IDLE: begin
                        r_video_go <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: begin
                        r_video_go <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
